// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-snapshot multiplexed driver for an 8-digit common-anode display.
// Leading-zero blanking is compiled in when LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  blink_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        frame_o
);
    localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  GUARD_END = CNT_W'(GUARD_CYCLES);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        idx;
    logic [FCNT_W-1:0] frame_cnt;
    logic              phase;
    logic [31:0]       sh_data;
    logic [7:0]        sh_dp;
    logic [7:0]        sh_blink;

    logic              slot_end;
    logic              frame_end;
    logic              dark;
    logic [3:0]        digit;
    logic [7:0]        an_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 3'd7);
    assign digit     = sh_data[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] msd;
    logic [2:0] msd_nxt;

    // msd is taken from the incoming word so it is valid alongside the new snapshot.
    always_comb begin
        msd_nxt = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (data_i[4*k +: 4] != 4'd0) begin
                msd_nxt = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msd <= '0;
        end else if (frame_end) begin
            msd <= msd_nxt;
        end
    end
`endif

    always_comb begin
        dark = (cnt < GUARD_END) || (sh_blink[idx] && phase);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx > msd) && !sh_dp[idx]) begin
            dark = 1'b1;
        end
`endif
        if (dark) begin
            an_nxt  = '1;
            seg_nxt = '1;
            dp_nxt  = 1'b1;
        end else begin
            an_nxt  = ~(8'd1 << idx);
            seg_nxt = decode(digit);
            dp_nxt  = ~sh_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            phase     <= 1'b0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blink  <= '0;
            frame_o   <= 1'b0;
            an_o      <= '1;
            seg_o     <= '1;
            dp_o      <= 1'b1;
        end else begin
            cnt     <= slot_end ? '0 : cnt + 1'b1;
            frame_o <= frame_end;
            an_o    <= an_nxt;
            seg_o   <= seg_nxt;
            dp_o    <= dp_nxt;
            if (slot_end) begin
                idx <= idx + 1'b1;
            end
            if (frame_end) begin
                sh_data  <= data_i;
                sh_dp    <= dp_i;
                sh_blink <= blink_i;
                if (frame_cnt == FCNT_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule
